// File: rtl/fpga_edge_io_ring.sv
// Scan-configured I/O ring segment: per-pad input/output modes and output enables,
// loaded through a serial shift register and applied on an explicit commit.
module fpga_edge_io_ring #(
    parameter int NUM_IO   = 10,
    parameter int CFG_BITS = 4
) (
    input  logic              scan_clk,
    input  logic              rst_n,
    input  logic              conn_scan_en,
    input  logic              conn_scan_in,
    output logic              conn_scan_out,
    input  logic              cfg_commit,
    output logic              cfg_active,
    input  logic [NUM_IO-1:0] pad_in,
    output logic [NUM_IO-1:0] fabric_in,
    input  logic [NUM_IO-1:0] fabric_out,
    output logic [NUM_IO-1:0] pad_out,
    output logic [NUM_IO-1:0] pad_oe
);

    localparam int L = NUM_IO * CFG_BITS;

    logic [L-1:0]      sreg_r;
    logic [L-1:0]      act_r;
    logic              cfg_active_r;
    logic [NUM_IO-1:0] r1_r;
    logic [NUM_IO-1:0] r2_r;
    logic [NUM_IO-1:0] ro_r;
    logic [NUM_IO-1:0] fabric_in_s;
    logic [NUM_IO-1:0] pad_out_s;
    logic [NUM_IO-1:0] pad_oe_s;

    // Config shift register; the first bit shifted in ends up at the MSB.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r <= '0;
        end else if (conn_scan_en) begin
            sreg_r <= {sreg_r[L-2:0], conn_scan_in};
        end else begin
            sreg_r <= sreg_r;
        end
    end

    // Active config; a commit during a shift cycle is ignored.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r        <= '0;
            cfg_active_r <= 1'b0;
        end else if (cfg_commit && !conn_scan_en) begin
            act_r        <= sreg_r;
            cfg_active_r <= 1'b1;
        end else begin
            act_r        <= act_r;
            cfg_active_r <= cfg_active_r;
        end
    end

    // Pad flops run every cycle so a mode switch never needs a pipeline refill.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_r <= '0;
            r2_r <= '0;
            ro_r <= '0;
        end else begin
            r1_r <= pad_in;
            r2_r <= r1_r;
            ro_r <= fabric_out;
        end
    end

    // Per-pad selection of input path, output path and output enable.
    always_comb begin
        fabric_in_s = '0;
        pad_out_s   = '0;
        pad_oe_s    = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            case (act_r[CFG_BITS*i +: 2])
                2'b00:   fabric_in_s[i] = 1'b0;
                2'b01:   fabric_in_s[i] = pad_in[i];
                2'b10:   fabric_in_s[i] = r1_r[i];
                2'b11:   fabric_in_s[i] = r2_r[i];
                default: fabric_in_s[i] = 1'b0;
            endcase
            pad_oe_s[i] = act_r[CFG_BITS*i + 3];
            if (!act_r[CFG_BITS*i + 3]) begin
                pad_out_s[i] = 1'b0;
            end else if (act_r[CFG_BITS*i + 2]) begin
                pad_out_s[i] = ro_r[i];
            end else begin
                pad_out_s[i] = fabric_out[i];
            end
        end
    end

    assign conn_scan_out = sreg_r[L-1];
    assign cfg_active    = cfg_active_r;
    assign fabric_in     = fabric_in_s;
    assign pad_out       = pad_out_s;
    assign pad_oe        = pad_oe_s;

endmodule

// File: tb/tb_fpga_edge_io_ring.sv
// Self-checking bench for fpga_edge_io_ring: a queue/history based reference model
// compared every falling edge, plus hand-computed literal checks.
module tb_fpga_edge_io_ring;

    localparam int NUM_IO = 10;
    localparam int L      = NUM_IO * 4;

    logic              scan_clk = 1'b0;
    logic              rst_n;
    logic              conn_scan_en;
    logic              conn_scan_in;
    logic              conn_scan_out;
    logic              cfg_commit;
    logic              cfg_active;
    logic [NUM_IO-1:0] pad_in;
    logic [NUM_IO-1:0] fabric_in;
    logic [NUM_IO-1:0] fabric_out;
    logic [NUM_IO-1:0] pad_out;
    logic [NUM_IO-1:0] pad_oe;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic rand_io = 1'b1;

    fpga_edge_io_ring #(.NUM_IO(NUM_IO), .CFG_BITS(4)) dut (
        .scan_clk(scan_clk), .rst_n(rst_n),
        .conn_scan_en(conn_scan_en), .conn_scan_in(conn_scan_in),
        .conn_scan_out(conn_scan_out), .cfg_commit(cfg_commit),
        .cfg_active(cfg_active), .pad_in(pad_in), .fabric_in(fabric_in),
        .fabric_out(fabric_out), .pad_out(pad_out), .pad_oe(pad_oe)
    );

    always #5 scan_clk = ~scan_clk;

    // Reference model: chain as a bit queue (front = oldest bit = MSB), pad history.
    logic              m_q[$];
    logic [3:0]        m_cfg[NUM_IO];
    logic              m_active;
    logic [NUM_IO-1:0] m_pin1, m_pin2, m_fo1;

    always @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            repeat (L) m_q.push_back(1'b0);
            for (int i = 0; i < NUM_IO; i++) m_cfg[i] = 4'b0000;
            m_active = 1'b0;
            m_pin1 = '0; m_pin2 = '0; m_fo1 = '0;
        end else begin
            if (conn_scan_en) begin
                m_q.push_back(conn_scan_in);
                void'(m_q.pop_front());
            end else if (cfg_commit) begin
                for (int i = 0; i < NUM_IO; i++)
                    for (int b = 0; b < 4; b++)
                        m_cfg[i][b] = m_q[L-1-(4*i+b)];
                m_active = 1'b1;
            end
            m_pin2 = m_pin1;
            m_pin1 = pad_in;
            m_fo1  = fabric_out;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge scan_clk) begin
        logic [NUM_IO-1:0] e_fi, e_po, e_oe;
        e_fi = '0; e_po = '0; e_oe = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            case (m_cfg[i][1:0])
                2'd1:    e_fi[i] = pad_in[i];
                2'd2:    e_fi[i] = m_pin1[i];
                2'd3:    e_fi[i] = m_pin2[i];
                default: e_fi[i] = 1'b0;
            endcase
            e_oe[i] = m_cfg[i][3];
            e_po[i] = m_cfg[i][3] ? (m_cfg[i][2] ? m_fo1[i] : fabric_out[i]) : 1'b0;
        end
        check("model_fabric_in", 64'(fabric_in), 64'(e_fi));
        check("model_pad_out", 64'(pad_out), 64'(e_po));
        check("model_pad_oe", 64'(pad_oe), 64'(e_oe));
        check("model_scan_out", 64'(conn_scan_out), 64'(m_q[0]));
        check("model_cfg_active", 64'(cfg_active), 64'(m_active));
    end

    task automatic tick();
        logic [31:0] rnd;
        @(posedge scan_clk);
        #1;
        if (rand_io) begin
            rnd = $urandom(); pad_in = rnd[NUM_IO-1:0];
            rnd = $urandom(); fabric_out = rnd[NUM_IO-1:0];
        end
    endtask

    task automatic shift_bits(input logic [L-1:0] v, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            conn_scan_en = 1'b1;
            conn_scan_in = v[L-1-k];
            tick();
        end
        conn_scan_en = 1'b0;
        conn_scan_in = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        logic [L-1:0] cfg_a, cfg_b, rb;
        cfg_a = 40'h00_0000_03E9;
        cfg_b = 40'h00_0000_03E3;
        rb    = '0;
        rst_n = 1'b0; conn_scan_en = 1'b0; conn_scan_in = 1'b0; cfg_commit = 1'b0;
        pad_in = '0; fabric_out = '0;

        // Reset held with random pins.
        repeat (4) tick();
        @(negedge scan_clk);
        check("rst_fabric_in", 64'(fabric_in), 64'h0);
        check("rst_pad_out", 64'(pad_out), 64'h0);
        check("rst_pad_oe", 64'(pad_oe), 64'h0);
        check("rst_cfg_active", 64'(cfg_active), 64'h0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Commit together with shift: ignored, but the shift happens.
        conn_scan_en = 1'b1; conn_scan_in = 1'b1; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        @(negedge scan_clk);
        check("shiftcommit_active", 64'(cfg_active), 64'h0);
        check("shiftcommit_oe", 64'(pad_oe), 64'h0);
        shift_bits('0, L - 1);
        @(negedge scan_clk);
        check("shiftcommit_bit_at_msb", 64'(conn_scan_out), 64'h1);

        // Partial load then async reset mid-cycle.
        shift_bits(cfg_a, 17);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_scan_out", 64'(conn_scan_out), 64'h0);
        check("async_rst_pad_out", 64'(pad_out), 64'h0);
        check("async_rst_fabric_in", 64'(fabric_in), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full load and commit.
        shift_bits(cfg_a, L);
        commit();
        @(negedge scan_clk);
        check("load_pad_oe", 64'(pad_oe), 64'h003);
        check("load_cfg_active", 64'(cfg_active), 64'h1);
        repeat (20) tick();

        // Hand-traced latencies: pads 0/1/2 direct/registered/sync.
        rand_io = 1'b0;
        pad_in = 10'h007; fabric_out = 10'h003;
        repeat (3) tick();
        @(negedge scan_clk);
        check("lat_fi_steady", 64'(fabric_in), 64'h007);
        check("lat_po_steady", 64'(pad_out), 64'h003);
        tick();
        pad_in = 10'h000; fabric_out = 10'h000;
        @(negedge scan_clk);
        check("lat_fi_c0", 64'(fabric_in), 64'h006);
        check("lat_po_c0", 64'(pad_out), 64'h002);
        tick();
        @(negedge scan_clk);
        check("lat_fi_c1", 64'(fabric_in), 64'h004);
        check("lat_po_c1", 64'(pad_out), 64'h000);
        tick();
        @(negedge scan_clk);
        check("lat_fi_c2", 64'(fabric_in), 64'h000);
        rand_io = 1'b1;
        tick();

        // Readback: chain contents appear MSB first.
        for (int k = 0; k < L; k++) begin
            conn_scan_en = 1'b1;
            conn_scan_in = 1'b0;
            @(negedge scan_clk);
            rb[L-1-k] = conn_scan_out;
            tick();
        end
        conn_scan_en = 1'b0;
        check("readback_vector", 64'(rb), 64'(cfg_a));
        @(negedge scan_clk);
        check("readback_oe_kept", 64'(pad_oe), 64'h003);

        // Live reconfig of pad0 from direct to sync.
        rand_io = 1'b0;
        pad_in = '0; fabric_out = '0;
        tick();
        shift_bits(cfg_b, L);
        pad_in[0] = 1'b1;
        tick();
        pad_in[0] = 1'b0; cfg_commit = 1'b1;
        @(negedge scan_clk);
        check("live_direct_before", 64'(fabric_in[0]), 64'h0);
        tick();
        cfg_commit = 1'b0;
        @(negedge scan_clk);
        check("live_sync_after", 64'(fabric_in[0]), 64'h1);
        check("live_oe_after", 64'(pad_oe), 64'h002);
        rand_io = 1'b1;
        repeat (10) tick();

        @(negedge scan_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
